// File: rtl/mdu_hilo_writer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_hilo_writer
//  Description : Iterative multiply/divide unit producing HI/LO results.
//                One shift-add (multiply) or restoring shift-subtract
//                (divide) step per clock on operand magnitudes, followed by
//                sign correction. Divide-by-zero completes without iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo_writer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // product sign, or quotient sign
  logic             neg_rem_q, neg_rem_d;   // remainder sign (signed divide only)
  logic [WIDTH-1:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;     // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;     // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  // Operand magnitudes and per-step datapath values
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Next-state, datapath step and result loading
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;

    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_res_q ? -prod : prod;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op[1] && (b == '0)) begin
            // Divide by zero finishes immediately with a fixed result
            state_d = DONE;
            hi_d    = a;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d   = CALC;
            cnt_d     = '0;
            is_div_d  = op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg & op[1];
            opnd_d    = op[1] ? mag_b : mag_a;
            acc_lo_d  = op[1] ? mag_a : mag_b;
            acc_hi_d  = '0;
          end
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          dz_d    = 1'b0;
          if (is_div_q) begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (is_div_q) begin
            // Restore-free form: keep the shifted value when the subtract borrows
            if (!div_diff[WIDTH]) begin
              acc_hi_d = div_diff[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_shift[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_hilo_writer
//  Description : Self-checking bench for mdu_hilo_writer. Expected results are
//                pushed to a scoreboard when an operation is issued and popped
//                when done pulses; scenario tasks add latency/flag checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo_writer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  mdu_hilo_writer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Reference model built on the language's own arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (o[1] && y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      case (o)
        2'd0: begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          p  = 64'(sx * sy);
          e.hi = p[63:32];
          e.lo = p[31:0];
        end
        2'd1: begin
          p = {32'b0, x} * {32'b0, y};
          e.hi = p[63:32];
          e.lo = p[31:0];
        end
        2'd2: begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q  = sx / sy;
          r  = sx % sy;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
        default: begin
          e.lo = x / y;
          e.hi = x % y;
        end
      endcase
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected_done: got done=1 with no pending operation, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        compared++;
        if (hi_out !== e.hi) begin
          mismatched++;
          $display("FAIL sb_hi: got %h required %h", hi_out, e.hi);
        end
        compared++;
        if (lo_out !== e.lo) begin
          mismatched++;
          $display("FAIL sb_lo: got %h required %h", lo_out, e.lo);
        end
        compared++;
        if (div_zero !== e.dz) begin
          mismatched++;
          $display("FAIL sb_div_zero: got %b required %b", div_zero, e.dz);
        end
      end
    end
  end

  // Drive one start pulse; returns at the negedge just after the accepting edge
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Count negedges (1 = cycle right after the accepting edge) until done
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, done, div_zero, hi_out, lo_out} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h required all zero",
               busy, done, div_zero, hi_out, lo_out);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_multu_max();
    int n;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL multu_busy: got %b required 1", busy);
    end
    wait_done(n);
    compared++;
    if (n != 34) begin
      mismatched++;
      $display("FAIL multu_latency: got cycle %0d required 34", n);
    end
    compared++;
    if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001 || div_zero !== 1'b0) begin
      mismatched++;
      $display("FAIL multu_max: got hi=%h lo=%h dz=%b required FFFFFFFE 00000001 0",
               hi_out, lo_out, div_zero);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL multu_pulse_width: got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_mult_signed();
    int n;
    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    compared++;
    if (n != 34 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA) begin
      mismatched++;
      $display("FAIL mult_signed: got cycle=%0d hi=%h lo=%h required 34 FFFFFFFF FFFFFFFA",
               n, hi_out, lo_out);
    end
  endtask

  task automatic test_div_signed();
    int n;
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    compared++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
      mismatched++;
      $display("FAIL div_neg7_by2: got hi=%h lo=%h required FFFFFFFF FFFFFFFD", hi_out, lo_out);
    end
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    compared++;
    if (hi_out !== 32'h0 || lo_out !== 32'h8000_0000 || div_zero !== 1'b0) begin
      mismatched++;
      $display("FAIL div_overflow: got hi=%h lo=%h dz=%b required 00000000 80000000 0",
               hi_out, lo_out, div_zero);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(2'd3, 32'h64, 32'h0);
    wait_done(n);
    compared++;
    if (n != 1) begin
      mismatched++;
      $display("FAIL divzero_latency: got cycle %0d required 1", n);
    end
    compared++;
    if (hi_out !== 32'h64 || lo_out !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
      mismatched++;
      $display("FAIL divzero_result: got hi=%h lo=%h dz=%b required 00000064 FFFFFFFF 1",
               hi_out, lo_out, div_zero);
    end
    issue(2'd1, 32'd2, 32'd3);
    repeat (10) @(negedge clk);
    compared++;
    if (hi_out !== 32'h64 || lo_out !== 32'hFFFF_FFFF || div_zero !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_during_calc: got hi=%h lo=%h dz=%b busy=%b required 00000064 FFFFFFFF 1 1",
               hi_out, lo_out, div_zero, busy);
    end
    wait_done(n);
    compared++;
    if (div_zero !== 1'b0 || lo_out !== 32'd6 || hi_out !== 32'd0) begin
      mismatched++;
      $display("FAIL divzero_clear: got dz=%b hi=%h lo=%h required 0 00000000 00000006",
               div_zero, hi_out, lo_out);
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    issue(2'd1, 32'h1234, 32'h5678);
    // Pulses land on edges 5, 33 (last CALC edge) and 34 (leaving DONE)
    for (int k = 1; k <= 34; k++) begin
      start = (k == 5 || k == 33 || k == 34);
      op    = 2'($urandom_range(0, 3));
      a     = $urandom;
      b     = $urandom;
      @(negedge clk);
      if (k == 33) begin
        compared++;
        if (done !== 1'b1 || lo_out !== 32'h0626_0060 || hi_out !== 32'h0) begin
          mismatched++;
          $display("FAIL start_ignored_result: got done=%b hi=%h lo=%h required 1 00000000 06260060",
                   done, hi_out, lo_out);
        end
      end
    end
    start = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    compared++;
    if (extra != 0 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL start_ignored_idle: got %0d busy cycles, %0d pending required 0 0",
               extra, sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int pulses;
    issue(2'd1, 32'h1111, 32'h2222);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_abort_immediate: got busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
               busy, done, hi_out, lo_out);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL reset_abort_no_done: got %0d active cycles required 0", pulses);
    end
    issue(2'd1, 32'd7, 32'd6);
    wait_done(n);
    compared++;
    if (n != 34 || lo_out !== 32'd42 || hi_out !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_abort_next: got cycle=%0d hi=%h lo=%h required 34 00000000 0000002A",
               n, hi_out, lo_out);
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [1:0]  o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'(i % 4);
      x = $urandom;
      y = $urandom;
      if (i % 3 == 0) y = y >> $urandom_range(0, 31);
      if (i == 6) y = '0;
      issue(o, x, y);
      wait_done(n);
      compared++;
      if (n != ((o[1] && y == '0) ? 1 : 34)) begin
        mismatched++;
        $display("FAIL b2b_latency[%0d]: got cycle %0d for op=%0d b=%h", i, n, o, y);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d pending results required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mdu_hilo_writer.md
MDU_HILO_WRITER -- requirements
Module: mdu_hilo_writer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO.
REQ-002 The module SHALL have port clk, input, 1 bit: clock; all state changes occur on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The module SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The module SHALL have port a, input, WIDTH bits: multiplicand, or dividend for DIV/DIVU.
REQ-007 The module SHALL have port b, input, WIDTH bits: multiplier, or divisor for DIV/DIVU.
REQ-008 The module SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse; hi_out/lo_out valid and intended as the HI/LO register write enable.
REQ-010 The module SHALL have port hi_out, output, WIDTH bits: product high half for multiplies, remainder for divides.
REQ-011 The module SHALL have port lo_out, output, WIDTH bits: product low half for multiplies, quotient for divides.
REQ-012 The module SHALL have port div_zero, output, 1 bit: the last completed operation was a divide with b == 0.

Function
REQ-013 The module SHALL implement a state machine with states IDLE, CALC and DONE; busy SHALL be 1 whenever the state is not IDLE, and done SHALL be 1 only in DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op, a and b on the edge (edge E0) and go to CALC with the iteration counter at 0; the exception is a divide with b == 0 (REQ-019).
REQ-015 While busy=1, start SHALL be ignored, including in the DONE cycle, and the latched operands SHALL NOT change.
REQ-016 CALC SHALL perform one iteration per edge, on edges E1 through E32: shift-add for multiplies, restoring shift-subtract for divides, on operand magnitudes.
REQ-017 On edge E33, CALC SHALL go to DONE and load hi_out/lo_out with the sign-corrected result, so done=1 for exactly the cycle between E33 and E34; DONE SHALL return to IDLE on E34.
REQ-018 Sign rules:
- MULT result SHALL be the 64-bit two's-complement product.
- DIV quotient sign SHALL be sign(a) XOR sign(b).
- DIV remainder sign SHALL equal sign(a).
- MULTU/DIVU SHALL treat both operands as unsigned.
REQ-019 For a divide with b == 0, IDLE SHALL go directly to DONE on E0 and load hi_out=a, lo_out=all ones, div_zero=1, so done=1 in the cycle after E0.
REQ-020 For any other completed operation, div_zero SHALL be loaded with 0 at the same edge that hi_out/lo_out are loaded.
REQ-021 DIV with a=0x80000000, b=0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0, with no exception raised.
REQ-022 hi_out, lo_out and div_zero SHALL hold their values from one DONE to the next, unchanged through IDLE and CALC.
REQ-023 The outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 While rst=1, independent of clk, the state SHALL be IDLE and busy, done, div_zero, hi_out, lo_out and the iteration counter SHALL all be 0.
REQ-025 Reset asserted in CALC or DONE SHALL abort the operation with no done pulse; after release, the first start SHALL run normally.

Verification
REQ-026 The bench SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 edges after E0; hi_out=0xFFFFFFFE, lo_out=0x00000001, div_zero=0.
REQ-027 The bench SHALL cover: MULT a=0xFFFFFFFE (-2), b=3 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA.
REQ-028 The bench SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
REQ-029 The bench SHALL cover: DIVU a=0x64, b=0 -> done in the cycle after E0; hi_out=0x64, lo_out=0xFFFFFFFF, div_zero=1; a following MULTU 2*3 clears div_zero and gives lo_out=6.
REQ-030 The bench SHALL cover: start with new operands pulsed on cycles 5 and 33 after E0 -> both ignored, and the result matches the first operands.
REQ-031 The bench SHALL cover: rst pulsed at cycle 10 of CALC -> busy=0, done=0, hi_out=lo_out=0 immediately; no done pulse follows; the next MULTU 7*6 gives lo_out=42.
